// File: rtl/btn_event_decoder_pkg.sv
// ============================================================================
// btn_event_decoder_pkg: shared state encodings and timer commands.
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_event_decoder_pkg;

    // Encodings are also decoded by the shutdown controller; keep values fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TMR_HOLD  = 2'd0,
        TMR_CLEAR = 2'd1,
        TMR_LOAD1 = 2'd2,
        TMR_INC   = 2'd3
    } tmr_op_e;

endpackage

`default_nettype wire

// File: rtl/btn_event_decoder_cycle_timer.sv
// ============================================================================
// btn_event_decoder_cycle_timer: cycle counter with clear, load-1, increment
// and an equality terminal-count compare.  Revision: 1.0
// ============================================================================
`default_nettype none

module btn_event_decoder_cycle_timer
    import btn_event_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  tmr_op_e              op,
    input  logic [CNT_WIDTH-1:0] term,
    output logic                 at_term
);

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case (op)
            TMR_CLEAR: cnt_d = '0;
            TMR_LOAD1: cnt_d = CNT_WIDTH'(1);
            TMR_INC:   cnt_d = cnt_q + CNT_WIDTH'(1);
            default:   cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term);

endmodule

`default_nettype wire

// File: rtl/btn_event_decoder.sv
// ============================================================================
// btn_event_decoder: classifies the debounced button into short, double and
// long press events plus a held level.  Revision: 1.0
// ============================================================================
`default_nettype none

module btn_event_decoder
    import btn_event_decoder_pkg::*;
#(
    parameter int CNT_WIDTH   = 26,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic enable,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic held,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] LONG_TERM = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_TERM  = CNT_WIDTH'(GAP_CYCLES);

    state_e               state_d, state_q;
    logic                 btn_prev_q;
    logic                 short_d, short_q;
    logic                 double_d, double_q;
    logic                 long_d, long_q;
    logic                 held_d, held_q;
    logic                 busy_d, busy_q;
    tmr_op_e              tmr_op;
    logic [CNT_WIDTH-1:0] tmr_term;
    logic                 at_term;
    logic                 rise;

    assign rise = btn_level & ~btn_prev_q;

    btn_event_decoder_cycle_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (tmr_op),
        .term    (tmr_term),
        .at_term (at_term)
    );

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        held_d   = held_q;
        tmr_op   = TMR_HOLD;
        tmr_term = (state_q == ST_WAIT2) ? GAP_TERM : LONG_TERM;

        if (!enable) begin
            state_d = ST_IDLE;
            held_d  = 1'b0;
            tmr_op  = TMR_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_PRESS1;
                        tmr_op  = TMR_LOAD1;
                    end
                end
                ST_PRESS1: begin
                    if (!btn_level) begin
                        state_d = ST_WAIT2;
                        tmr_op  = TMR_LOAD1;
                    end else if (at_term) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        held_d  = 1'b1;
                    end else begin
                        tmr_op = TMR_INC;
                    end
                end
                ST_WAIT2: begin
                    // A high sample wins even on the terminal gap count.
                    if (btn_level) begin
                        state_d = ST_PRESS2;
                        tmr_op  = TMR_LOAD1;
                    end else if (at_term) begin
                        state_d = ST_IDLE;
                        short_d = 1'b1;
                        tmr_op  = TMR_CLEAR;
                    end else begin
                        tmr_op = TMR_INC;
                    end
                end
                ST_PRESS2: begin
                    if (!btn_level) begin
                        state_d  = ST_IDLE;
                        double_d = 1'b1;
                        tmr_op   = TMR_CLEAR;
                    end else if (at_term) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        held_d  = 1'b1;
                    end else begin
                        tmr_op = TMR_INC;
                    end
                end
                ST_LONG: begin
                    if (!btn_level) begin
                        state_d = ST_IDLE;
                        held_d  = 1'b0;
                        tmr_op  = TMR_CLEAR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                    tmr_op  = TMR_CLEAR;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // btn_prev resets high so a button held through reset never counts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            btn_prev_q <= 1'b1;
            short_q    <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_level;
            short_q    <= short_d;
            double_q   <= double_d;
            long_q     <= long_d;
            held_q     <= held_d;
            busy_q     <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign held         = held_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
// ============================================================================
// tb_btn_event_decoder: directed vector table plus reset corner sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_btn_event_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_level;
    logic enable;
    logic short_press, double_press, long_press, held, busy;

    always #5 clk = ~clk;

    btn_event_decoder #(
        .CNT_WIDTH   (4),
        .LONG_CYCLES (8),
        .GAP_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .enable       (enable),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .held         (held),
        .busy         (busy)
    );

    // Expected output word: {short, double, long, held, busy}
    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] B  = 5'b00001;
    localparam logic [4:0] S  = 5'b10000;
    localparam logic [4:0] D  = 5'b01000;
    localparam logic [4:0] LH = 5'b00111;
    localparam logic [4:0] H  = 5'b00011;

    typedef struct packed {
        logic       btn;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic b, input logic e, input logic [4:0] x, input int n = 1);
        for (int i = 0; i < n; i++) tbl.push_back('{btn: b, en: e, exp: x});
    endtask

    task automatic check(input string tag, input int idx, input logic [4:0] exp);
        logic [4:0] act;
        act = {short_press, double_press, long_press, held, busy};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got {s,d,l,h,b}=%b expected %b", tag, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        btn_level = v.btn;
        enable    = v.en;
        @(posedge clk);
        #1;
        check(tag, idx, v.exp);
    endtask

    task automatic run_seq(input string tag, input int n, input logic b, input logic e,
                           input logic [4:0] x);
        for (int i = 0; i < n; i++) apply('{btn: b, en: e, exp: x}, tag, i);
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_level = 1'b0;
        enable    = 1'b1;
        #12;
        check("reset_state", 0, Z);
        @(negedge clk);
        rst_n = 1'b1;

        add(0, 1, Z, 2);
        // Short: short pulse after the 4th low sample that follows the release sample.
        add(1, 1, B, 3); add(0, 1, B, 4); add(0, 1, S); add(0, 1, Z, 5);
        // Double: press 3, low 2, press 3, release.
        add(1, 1, B, 3); add(0, 1, B, 2); add(1, 1, B, 3); add(0, 1, D); add(0, 1, Z, 6);
        // Second press sampled exactly on the terminal gap count is still a double.
        add(1, 1, B); add(0, 1, B, 4); add(1, 1, B); add(0, 1, D); add(0, 1, Z, 6);
        // Long press of 20 cycles.
        add(1, 1, B, 7); add(1, 1, LH); add(1, 1, H, 12); add(0, 1, Z, 3);
        // Press of 7 cycles is short only.
        add(1, 1, B, 7); add(0, 1, B, 4); add(0, 1, S); add(0, 1, Z, 2);
        // Long press reached from the second click.
        add(1, 1, B); add(0, 1, B); add(1, 1, B, 7); add(1, 1, LH); add(1, 1, H, 2); add(0, 1, Z, 2);
        // Enable dropped in WAIT2 after two low samples.
        add(1, 1, B, 3); add(0, 1, B, 2); add(0, 0, Z); add(0, 1, Z, 6);
        // Press while disabled is tracked, so re-enabling mid-press is not a rise.
        add(1, 0, Z, 3); add(1, 1, Z, 2); add(0, 1, Z, 2);
        // Enable dropped while held.
        add(1, 1, B, 7); add(1, 1, LH); add(1, 0, Z); add(1, 1, Z, 2); add(0, 1, Z, 2);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table", i);

        // Button held through reset deassertion.
        @(negedge clk);
        btn_level = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("rst_hold_async", 0, Z);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("rst_hold_high", 15, 1'b1, 1'b1, Z);
        run_seq("rst_hold_low", 5, 1'b0, 1'b1, Z);

        // Reset asserted in the middle of PRESS1.
        run_seq("mid_press", 2, 1'b1, 1'b1, B);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", 0, Z);
        @(negedge clk);
        btn_level = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("post_rst_idle", 2, 1'b0, 1'b1, Z);
        run_seq("post_rst_press", 3, 1'b1, 1'b1, B);
        run_seq("post_rst_gap", 4, 1'b0, 1'b1, B);
        run_seq("post_rst_short", 1, 1'b0, 1'b1, S);
        run_seq("post_rst_tail", 3, 1'b0, 1'b1, Z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_event_decoder.md
# btn_event_decoder

Classifies the debounced push-button level into discrete user events for the shutdown controller: single short press, double press, and long press (press-and-hold). Sits directly downstream of the button debouncer. Emits one-cycle event pulses plus a `held` level that the shutdown FSM uses for arm/confirm logic.

## Interface
- `CNT_WIDTH`, 26: width of the shared cycle counter; must satisfy 2^CNT_WIDTH > max(LONG_CYCLES, GAP_CYCLES).
- `LONG_CYCLES`, 50_000_000: consecutive high samples that make a long press (1 s at 50 MHz); legal range ≥ 2.
- `GAP_CYCLES`, 12_500_000: maximum low samples between two presses of a double press (250 ms); legal range ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn_level`  in  1  debounced button, synchronous to `clk`, 1 = pressed.
- `enable`  in  1  decoder enable; low forces the idle state.
- `short_press`  out  1  one-cycle pulse: single press, no second press within the gap.
- `double_press`  out  1  one-cycle pulse: second press released.
- `long_press`  out  1  one-cycle pulse: hold threshold reached.
- `held`  out  1  high from `long_press` until release is sampled.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `btn_prev` register holds the previous sample of `btn_level`.
  - rise = `btn_level & ~btn_prev`.
  - `btn_prev` resets to 1, so a button held through reset is ignored until it is released and pressed again.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG. One counter `cnt` is shared by all states.
- IDLE:
  - rise → PRESS1, `cnt`=1.
- PRESS1:
  - btn high and `cnt`==LONG_CYCLES-1 → LONG; `long_press` and `held` are set.
  - btn high, otherwise → `cnt`++.
  - btn low → WAIT2, `cnt`=1.
- WAIT2:
  - btn high → PRESS2, `cnt`=1.
  - btn low and `cnt`==GAP_CYCLES → IDLE; `short_press` is set.
  - btn low, otherwise → `cnt`++.
- PRESS2:
  - btn low → IDLE; `double_press` is set.
  - btn high and `cnt`==LONG_CYCLES-1 → LONG; `long_press` is set and the first click is discarded.
  - btn high, otherwise → `cnt`++.
- LONG:
  - `held`=1 and no further pulses.
  - btn low → IDLE, `held`=0.
- `enable` low: synchronous return to IDLE, `cnt`=0, `held`=0, all pulses 0. `btn_prev` keeps tracking the input.
- At most one event pulse is high in any cycle.
- Counter never wraps: every path that reaches the terminal count leaves the state.
- Comparisons are equality only, with operands zero-extended to CNT_WIDTH.

## Timing
- All outputs are registered. Reset value of `short_press`, `double_press`, `long_press`, `held` and `busy` is 0. Reset state is IDLE with `cnt`=0.
- Long press:
  - `long_press` is high for exactly the one cycle after the edge that samples the LONG_CYCLES-th consecutive high.
  - `held` rises on the same edge.
- Short press: `short_press` is high for the cycle after the GAP_CYCLES-th consecutive low sample following release.
- Double press:
  - The second rise must be sampled at or before the GAP_CYCLES-th low sample. If that sample is high, the result is a double press, not a short press.
  - `double_press` is high for the cycle after the edge sampling the second release.
- `busy` rises the cycle after a rise and falls in the same cycle that the terminating pulse asserts (or when `held` falls).
- Reset mid-operation: outputs clear immediately (asynchronous); no pending event is emitted afterwards.

## Structure
- Put state encodings (3-bit localparams: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG=4) in the shared header `shutdown_defs.vh`. The shutdown controller decodes `busy`/`held` against the same file.
- Natural sub-module: `cycle_timer`, a CNT_WIDTH counter with load-1, increment, and an equality terminal-count compare. It is reusable by the shutdown FSM's timeout logic.
- Target size: about 150–200 lines including `cycle_timer`.

## Test plan
Bench parameters: LONG_CYCLES=8, GAP_CYCLES=4, `enable`=1 unless stated.
- Press 3 cycles, release, hold low 10 cycles → one `short_press` pulse the cycle after the 4th low sample; no other pulses.
- Press 3, low 2, press 3, release → one `double_press` after the second release sample; `short_press` never asserts.
- Press 20 cycles → `long_press` pulse after the 8th high sample; `held` high until the cycle after release; a press of exactly 7 cycles gives `short_press` only.
- Hold the button through `rst_n` deassertion for 15 cycles, then release and stay idle → no pulses and `busy` stays 0.
- Drop `enable` during WAIT2 (after 2 low samples) → IDLE next cycle; no `short_press`; `busy`=0.
- Assert `rst_n` low in the middle of PRESS1 → all outputs 0 immediately; a fresh 3-cycle press then produces a normal `short_press`.
